// File: rtl/score_display_pkg.sv
// Shared geometry and segment encoding for the two-digit score overlay.
package score_display_pkg;

  // Segment bit positions inside the 7-bit font mask
  localparam int unsigned SEG_TOP = 0;
  localparam int unsigned SEG_UL  = 1;
  localparam int unsigned SEG_UR  = 2;
  localparam int unsigned SEG_MID = 3;
  localparam int unsigned SEG_LL  = 4;
  localparam int unsigned SEG_LR  = 5;
  localparam int unsigned SEG_BOT = 6;

  // Digit cell geometry in pixels
  localparam int unsigned CELL_W = 16;
  localparam int unsigned CELL_H = 32;
  localparam int unsigned SEG_T  = 4;
  localparam int unsigned MID_LO = 14;
  localparam int unsigned MID_HI = 17;

  // Which segment regions cover local cell position (lx, ly).
  // Vertical bars overlap the middle band so the digit corners join up.
  function automatic logic [6:0] seg_region(input logic [3:0] lx, input logic [4:0] ly);
    logic left_col;
    logic right_col;
    logic upper;
    logic lower;
    logic [6:0] m;
    left_col  = (lx < 4'(SEG_T));
    right_col = (lx >= 4'(CELL_W - SEG_T));
    upper     = (ly <= 5'(MID_HI));
    lower     = (ly >= 5'(MID_LO));
    m          = '0;
    m[SEG_TOP] = (ly < 5'(SEG_T));
    m[SEG_MID] = upper && lower;
    m[SEG_BOT] = (ly >= 5'(CELL_H - SEG_T));
    m[SEG_UL]  = left_col && upper;
    m[SEG_UR]  = right_col && upper;
    m[SEG_LL]  = left_col && lower;
    m[SEG_LR]  = right_col && lower;
    return m;
  endfunction

endpackage

// File: rtl/score_display_counter.sv
// Saturating score counter with synchronous clear.
module score_counter
  import score_display_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_at_limit
);

  logic [W-1:0] r_count;

  // Clear wins over increment; the count holds once it reaches LIMIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != W'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_at_limit = (r_count == W'(LIMIT));

endmodule

// File: rtl/score_display.sv
// Two-digit score overlay: scores, game-over flag and a 2-stage pixel pipe
// that reads segment masks from an external registered digit ROM.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned X_LEFT    = 256,
  parameter int unsigned X_RIGHT   = 368,
  parameter int unsigned Y_TOP     = 16,
  parameter int unsigned WIN_SCORE = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_video_on,
  input  logic       i_point_l,
  input  logic       i_point_r,
  input  logic       i_clr,
  output logic [3:0] o_font_addr,
  input  logic [6:0] i_font_data,
  output logic       o_pixel,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic       o_game_over
);

  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic        w_x_in_left;
  logic        w_x_in_right;
  logic        w_y_in;
  logic        w_in_left;
  logic        w_in_right;
  logic [3:0]  w_lx;
  logic [4:0]  w_ly;
  logic [6:0]  w_region;
  logic        w_inc_l;
  logic        w_inc_r;
  logic        w_at_l;
  logic        w_at_r;

  logic        r_in_left;
  logic        r_in_right;
  logic [6:0]  r_region;
  logic        r_video_on;
  logic        r_pixel;
  logic        r_game_over;

  assign w_x_ext = {1'b0, i_x};
  assign w_y_ext = {1'b0, i_y};

  assign w_x_in_left  = (w_x_ext >= 11'(X_LEFT))  && (w_x_ext < 11'(X_LEFT + CELL_W));
  assign w_x_in_right = (w_x_ext >= 11'(X_RIGHT)) && (w_x_ext < 11'(X_RIGHT + CELL_W));
  assign w_y_in       = (w_y_ext >= 11'(Y_TOP))   && (w_y_ext < 11'(Y_TOP + CELL_H));
  assign w_in_left    = w_x_in_left && w_y_in;
  assign w_in_right   = w_x_in_right && w_y_in;

  assign w_lx     = w_x_in_right ? 4'(i_x - 10'(X_RIGHT)) : 4'(i_x - 10'(X_LEFT));
  assign w_ly     = 5'(i_y - 10'(Y_TOP));
  assign w_region = seg_region(w_lx, w_ly);

  // Address selection uses the column only, so the ROM word is ready a clock ahead
  assign o_font_addr = w_x_in_right ? o_score_r : o_score_l;

  assign w_inc_l = i_point_l && !r_game_over;
  assign w_inc_r = i_point_r && !r_game_over;

  score_counter #(
    .W     (4),
    .LIMIT (WIN_SCORE)
  ) u_score_l (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_clr),
    .i_inc      (w_inc_l),
    .o_count    (o_score_l),
    .o_at_limit (w_at_l)
  );

  score_counter #(
    .W     (4),
    .LIMIT (WIN_SCORE)
  ) u_score_r (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_clr),
    .i_inc      (w_inc_r),
    .o_count    (o_score_r),
    .o_at_limit (w_at_r)
  );

  // Game-over latches one clock after either score hits the limit, until clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_game_over <= 1'b0;
    end else if (i_clr) begin
      r_game_over <= 1'b0;
    end else begin
      r_game_over <= r_game_over || w_at_l || w_at_r;
    end
  end

  // Stage 1: capture cell membership and segment regions while the ROM reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_left  <= 1'b0;
      r_in_right <= 1'b0;
      r_region   <= '0;
      r_video_on <= 1'b0;
    end else begin
      r_in_left  <= w_in_left;
      r_in_right <= w_in_right;
      r_region   <= w_region;
      r_video_on <= i_video_on;
    end
  end

  // Stage 2: combine the registered regions with the returned segment mask
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= r_video_on && (r_in_left || r_in_right) && (|(r_region & i_font_data));
    end
  end

  assign o_pixel     = r_pixel;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with an external digit ROM model.
module tb_score_display;

  localparam int X_LEFT    = 256;
  localparam int X_RIGHT   = 368;
  localparam int Y_TOP     = 16;
  localparam int WIN_SCORE = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       video = 1'b0;
  logic       pl = 1'b0;
  logic       pr = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] font_addr;
  logic [6:0] font_data = '0;
  logic       pixel;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_display #(
    .X_LEFT    (X_LEFT),
    .X_RIGHT   (X_RIGHT),
    .Y_TOP     (Y_TOP),
    .WIN_SCORE (WIN_SCORE)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_x         (x),
    .i_y         (y),
    .i_video_on  (video),
    .i_point_l   (pl),
    .i_point_r   (pr),
    .i_clr       (clr),
    .o_font_addr (font_addr),
    .i_font_data (font_data),
    .o_pixel     (pixel),
    .o_score_l   (score_l),
    .o_score_r   (score_r),
    .o_game_over (game_over)
  );

  // Seven-segment digit shapes (b0 top, b1 UL, b2 UR, b3 mid, b4 LL, b5 LR, b6 bottom)
  function automatic logic [6:0] digit_segs(input int d);
    case (d)
      0: return 7'h77;
      1: return 7'h24;
      2: return 7'h5D;
      3: return 7'h6D;
      4: return 7'h2E;
      5: return 7'h6B;
      6: return 7'h7B;
      7: return 7'h25;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // External ROM: one-clock registered read
  always @(posedge clk) font_data <= digit_segs(int'(font_addr));

  // Geometric pixel rule: segment rectangles in cell-local coordinates
  function automatic bit model_pix(input int px, input int py, input bit vid, input int sl, input int sr);
    int lx, ly, d;
    int x0[7], x1[7], y0[7], y1[7];
    logic [6:0] segs;
    if (!vid) return 0;
    if (py < Y_TOP || py >= Y_TOP + 32) return 0;
    if (px >= X_LEFT && px < X_LEFT + 16) begin d = sl; lx = px - X_LEFT; end
    else if (px >= X_RIGHT && px < X_RIGHT + 16) begin d = sr; lx = px - X_RIGHT; end
    else return 0;
    ly = py - Y_TOP;
    x0 = '{0, 0, 12, 0, 0, 12, 0};
    x1 = '{15, 3, 15, 15, 3, 15, 15};
    y0 = '{0, 0, 0, 14, 14, 14, 28};
    y1 = '{3, 17, 17, 17, 31, 31, 31};
    segs = digit_segs(d);
    for (int s = 0; s < 7; s++)
      if (segs[s] && lx >= x0[s] && lx <= x1[s] && ly >= y0[s] && ly <= y1[s]) return 1;
    return 0;
  endfunction

  int  m_sl, m_sr;
  bit  m_go, m_p1, m_pix;

  // Reference model: scores, game-over and the two-clock pixel delay
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sl <= 0; m_sr <= 0; m_go <= 0; m_p1 <= 0; m_pix <= 0;
    end else begin
      m_p1  <= model_pix(int'(x), int'(y), video, m_sl, m_sr);
      m_pix <= m_p1;
      if (clr) begin
        m_sl <= 0; m_sr <= 0; m_go <= 0;
      end else begin
        if (pl && !m_go && m_sl < WIN_SCORE) m_sl <= m_sl + 1;
        if (pr && !m_go && m_sr < WIN_SCORE) m_sr <= m_sr + 1;
        m_go <= m_go || (m_sl == WIN_SCORE) || (m_sr == WIN_SCORE);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_pixel", int'(pixel), int'(m_pix));
      check("m_score_l", int'(score_l), m_sl);
      check("m_score_r", int'(score_r), m_sr);
      check("m_game_over", int'(game_over), int'(m_go));
      check("m_font_addr", int'(font_addr),
            (int'(x) >= X_RIGHT && int'(x) < X_RIGHT + 16) ? m_sr : m_sl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit l, input bit r);
    tick(); pl = l; pr = r;
    tick(); pl = 0; pr = 0;
  endtask

  task automatic do_clear();
    tick(); clr = 1;
    tick(); clr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_score_l", int'(score_l), 0);
    check("rst_score_r", int'(score_r), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_pixel", int'(pixel), 0);

    // Three left points
    repeat (3) pulse(1, 0);
    check("three_l", int'(score_l), 3);
    check("three_r", int'(score_r), 0);
    check("three_go", int'(game_over), 0);

    // Left digit 8, top-left corner lit, cell interior dark
    repeat (5) pulse(1, 0);
    tick(); x = 256; y = 16; video = 1;
    #1 check("addr8", int'(font_addr), 8);
    tick(); check("lag1_pixel", int'(pixel), 0);
    tick(); check("lag2_pixel", int'(pixel), 1);
    x = 262; y = 24;
    tick(); check("hold_pixel", int'(pixel), 1);
    tick(); check("interior_pixel", int'(pixel), 0);

    // Right digit 1 swept along row 20
    do_clear();
    pulse(0, 1);
    x = 0; y = 20; video = 1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i < 16) x = 10'(368 + i);
      if (i >= 2) check("sweep_r1", int'(pixel), (368 + i - 2 >= 380) ? 1 : 0);
    end

    // Area sweep over both cells with blanking mixed in
    pulse(1, 0); pulse(1, 0);
    for (int yy = 12; yy < 52; yy++)
      for (int xx = 250; xx < 391; xx++) begin
        tick(); x = 10'(xx); y = 10'(yy); video = ((xx + yy) % 7) != 0;
      end
    tick(); video = 0; x = 0; y = 0;

    // Right wins; tenth point saturates
    do_clear();
    repeat (9) pulse(0, 1);
    check("win_score_r", int'(score_r), 9);
    check("win_go_pre", int'(game_over), 0);
    tick(); check("win_go", int'(game_over), 1);
    pulse(0, 1);
    check("sat_score_r", int'(score_r), 9);
    check("sat_go", int'(game_over), 1);

    // Clear beats a coincident point
    tick(); clr = 1; pl = 1;
    tick(); clr = 0; pl = 0;
    check("clr_l", int'(score_l), 0);
    check("clr_r", int'(score_r), 0);
    check("clr_go", int'(game_over), 0);

    // Simultaneous points
    repeat (4) pulse(1, 1);
    pulse(1, 1);
    check("dual_l", int'(score_l), 5);
    check("dual_r", int'(score_r), 5);

    // Asynchronous reset while a pixel is lit
    do_clear();
    repeat (8) pulse(1, 0);
    tick(); x = 256; y = 16; video = 1;
    tick(); tick();
    check("pre_rst_pixel", int'(pixel), 1);
    #2 rst_n = 0;
    #1;
    check("async_pixel", int'(pixel), 0);
    check("async_score_l", int'(score_l), 0);
    check("async_score_r", int'(score_r), 0);
    check("async_go", int'(game_over), 0);
    video = 0;
    tick(); tick();
    #2 rst_n = 1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
